figure_render_ctl: RTL
======================

Name: figure_render_ctl

Overview:
- Sequences pixel reads from the playable-figure image ROMs (fire 26x26, water 19x26) for the two player figures and overlays the result on the incoming VGA stream.
- Sits between the background drawing stage and the output stage.
- Owns per-frame position latching (pos_valid/pos_ready handshake), computes the hit test and ROM address, arbitrates the single ROM read slot when the figures overlap, and delays timing to match ROM latency.

Parameters:
- FIRE_W, 26, fire figure width (px)
- FIRE_H, 26, fire figure height
- WATER_W, 19, water figure width
- WATER_H, 26, water figure height
- KEY_RGB, 12'h0F0, transparent colour; ROM pixels equal to this are not drawn

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hcount_in  in  11  horizontal pixel counter
- vcount_in  in  11  vertical line counter
- hblnk_in  in  1  horizontal blanking
- vblnk_in  in  1  vertical blanking
- hsync_in  in  1  horizontal sync
- vsync_in  in  1  vertical sync
- rgb_in  in  12  background pixel
- pos_valid  in  1  new positions offered
- pos_ready  out  1  positions accepted this cycle when pos_valid=1
- fire_x, fire_y  in  11 each  fire top-left
- water_x, water_y  in  11 each  water top-left
- water_prio  in  1  1 = water wins overlap; sampled with positions
- rom_addr  out  12  ROM address
- rom_sel  out  1  0 = fire ROM, 1 = water ROM
- rom_rgb  in  12  ROM data, valid 1 cycle after rom_addr
- hcount_out, vcount_out  out  11 each  timing delayed 2 cycles
- hblnk_out, vblnk_out, hsync_out, vsync_out  out  1 each  timing delayed 2 cycles
- rgb_out  out  12  composited pixel

Behaviour:
- Reset: all outputs 0; shadow positions 0; water_prio shadow 0; FSM in ACTIVE.
- FSM states:
  - ACTIVE: pos_ready=0. Enter VB_OPEN on the first cycle with vblnk_in=1.
  - VB_OPEN: pos_ready=1. On pos_valid&pos_ready, latch all positions and water_prio into shadow registers and go to VB_DONE.
  - VB_OPEN/VB_DONE: on vblnk_in=0, go to ACTIVE.
  - Result: at most one update per frame; an unaccepted offer waits for the next vblank.
  - pos_ready is combinational from state AND vblnk_in.
- Stage 1 (registered):
  - Compute fire_hit: hcount in [fx, fx+FIRE_W), vcount in [fy, fy+FIRE_H); water_hit likewise.
  - Compare with 12-bit unsigned sums; no wrap. Figures clipped at the right/bottom edge simply fail the compare.
  - Winner: the only hit. If both hit, water when prio=1, else fire.
  - rom_addr = row*W + col, with row = vcount - y and col = hcount - x.
  - rom_sel = winner; hit_d = any hit AND NOT blanking.
  - No hit: rom_addr=0, rom_sel=0.
- Stage 2 (registered): rgb_out = rom_rgb when hit_d and rom_rgb != KEY_RGB, else rgb_in delayed 2 cycles. Timing outputs are delayed 2 cycles.
- Total latency: 2 cycles, constant.
- Only the winner is read. A transparent winner pixel shows background, not the loser.
- Reset mid-frame: pipeline clears; outputs are black/0 until 2 cycles after release.

Optional Feature:
- FIGURE_FLIP_EN adds inputs fire_flip and water_flip (1 bit each), latched with the positions.
- When a flip bit is set, col = W-1-(hcount-x) (horizontal mirror).
- Without the macro, the ports are absent and no mirroring occurs.

Decomposition:
- Package figure_pkg holds:
  - sprite dimension localparams
  - KEY_RGB
  - enum typedef fig_state_t {ACTIVE, VB_OPEN, VB_DONE}
  - struct typedef vga_tim_t (hcount, vcount, blnk, sync) for the delay pipe
- Sub-module figure_hit_addr, instantiated twice: hit test plus address for one figure (row*W via multiply-by-constant).

Test Plan:
- Reset, fire at (100,200), hcount=100, vcount=200, rom_rgb=12'hF00 -> rom_addr=0, rom_sel=0 at cycle+1; rgb_out=F00 at cycle+2.
- Fire (100,200), pixel (125,225) -> rom_addr=675; pixel (126,225) -> background passes through.
- Water (300,100), pixel (318,125) -> rom_sel=1, rom_addr=25*19+18=493.
- Both at (50,50), pixel (55,55): water_prio=0 -> rom_sel=0, addr=5*26+5=135; water_prio=1 -> rom_sel=1, addr=5*19+5=100.
- pos_valid held during active video -> pos_ready=0 and shadows unchanged. At vblank start -> pos_ready=1, accept once; a second offer in the same vblank is not accepted.
- rom_rgb=KEY_RGB on a hit -> rgb_out = delayed rgb_in. Assert rst_n low mid-line -> all outputs 0 immediately.

Source files
------------

// File: rtl/figure_pkg.sv
// Shared types and constants for the player-figure overlay stage.
package figure_pkg;

  localparam int unsigned CW      = 11;
  localparam int unsigned AW      = 12;
  localparam int unsigned RGB_W   = 12;
  localparam int unsigned FIRE_W  = 26;
  localparam int unsigned FIRE_H  = 26;
  localparam int unsigned WATER_W = 19;
  localparam int unsigned WATER_H = 26;

  localparam logic [RGB_W-1:0] KEY_RGB = 12'h0F0;

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    VB_OPEN = 2'd1,
    VB_DONE = 2'd2
  } fig_state_t;

  // blnk/sync are {horizontal, vertical}
  typedef struct packed {
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic [1:0]    blnk;
    logic [1:0]    sync;
  } vga_tim_t;

endpackage

// File: rtl/figure_hit_addr.sv
// Hit test and ROM address for one figure of size W x H at (x, y).
module figure_hit_addr
  import figure_pkg::*;
#(
  parameter int unsigned W = 26,
  parameter int unsigned H = 26
) (
  input  logic [CW-1:0] hcount,
  input  logic [CW-1:0] vcount,
  input  logic [CW-1:0] x,
  input  logic [CW-1:0] y,
  input  logic          flip,
  output logic          hit_c,
  output logic [AW-1:0] addr_c
);

  logic [CW-1:0] row;
  logic [CW-1:0] col;
  logic [CW-1:0] col_m;
  logic          in_x;
  logic          in_y;

  // 12-bit sums so a figure near the right/bottom edge cannot wrap into view
  always_comb begin
    in_x  = ({1'b0, hcount} >= {1'b0, x}) && ({1'b0, hcount} < ({1'b0, x} + AW'(W)));
    in_y  = ({1'b0, vcount} >= {1'b0, y}) && ({1'b0, vcount} < ({1'b0, y} + AW'(H)));
    hit_c = in_x && in_y;
    row   = vcount - y;
    col   = hcount - x;
    col_m = flip ? (CW'(W - 1) - col) : col;
    addr_c = AW'(row) * AW'(W) + AW'(col_m);
  end

endmodule

// File: rtl/figure_render_ctl.sv
// Overlays the fire/water player figures on the VGA stream with 2-cycle latency.
// Optional FIGURE_FLIP_EN adds per-figure horizontal mirroring.
module figure_render_ctl
  import figure_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CW-1:0]    hcount_in,
  input  logic [CW-1:0]    vcount_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic [RGB_W-1:0] rgb_in,
  input  logic             pos_valid,
  output logic             pos_ready,
  input  logic [CW-1:0]    fire_x,
  input  logic [CW-1:0]    fire_y,
  input  logic [CW-1:0]    water_x,
  input  logic [CW-1:0]    water_y,
  input  logic             water_prio,
`ifdef FIGURE_FLIP_EN
  input  logic             fire_flip,
  input  logic             water_flip,
`endif
  output logic [AW-1:0]    rom_addr,
  output logic             rom_sel,
  input  logic [RGB_W-1:0] rom_rgb,
  output logic [CW-1:0]    hcount_out,
  output logic [CW-1:0]    vcount_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic [RGB_W-1:0] rgb_out
);

  fig_state_t state, state_nxt;
  logic          accept;
  logic [CW-1:0] fx_s, fy_s, wx_s, wy_s;
  logic          prio_s;
  logic          fflip_s, wflip_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACTIVE;
    else        state <= state_nxt;
  end

  // One position update per frame, only while vertical blanking is open
  always_comb begin
    state_nxt = state;
    pos_ready = 1'b0;
    case (state)
      ACTIVE:  if (vblnk_in) state_nxt = VB_OPEN;
      VB_OPEN: begin
        pos_ready = vblnk_in;
        if (!vblnk_in)      state_nxt = ACTIVE;
        else if (pos_valid) state_nxt = VB_DONE;
      end
      VB_DONE: if (!vblnk_in) state_nxt = ACTIVE;
      default: state_nxt = ACTIVE;
    endcase
  end

  assign accept = pos_valid & pos_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fx_s    <= '0;
      fy_s    <= '0;
      wx_s    <= '0;
      wy_s    <= '0;
      prio_s  <= 1'b0;
      fflip_s <= 1'b0;
      wflip_s <= 1'b0;
    end else if (accept) begin
      fx_s    <= fire_x;
      fy_s    <= fire_y;
      wx_s    <= water_x;
      wy_s    <= water_y;
      prio_s  <= water_prio;
`ifdef FIGURE_FLIP_EN
      fflip_s <= fire_flip;
      wflip_s <= water_flip;
`else
      fflip_s <= 1'b0;
      wflip_s <= 1'b0;
`endif
    end
  end

  logic          fire_hit, water_hit;
  logic [AW-1:0] fire_addr, water_addr;

  figure_hit_addr #(.W(FIRE_W), .H(FIRE_H)) u_fire (
    .hcount (hcount_in),
    .vcount (vcount_in),
    .x      (fx_s),
    .y      (fy_s),
    .flip   (fflip_s),
    .hit_c  (fire_hit),
    .addr_c (fire_addr)
  );

  figure_hit_addr #(.W(WATER_W), .H(WATER_H)) u_water (
    .hcount (hcount_in),
    .vcount (vcount_in),
    .x      (wx_s),
    .y      (wy_s),
    .flip   (wflip_s),
    .hit_c  (water_hit),
    .addr_c (water_addr)
  );

  logic          pick_water;
  logic          any_hit;
  logic [AW-1:0] addr_nxt;

  always_comb begin
    pick_water = water_hit & (~fire_hit | prio_s);
    any_hit    = fire_hit | water_hit;
    addr_nxt   = '0;
    if (any_hit) addr_nxt = pick_water ? water_addr : fire_addr;
  end

  vga_tim_t         tim_d1, tim_d2;
  logic [RGB_W-1:0] rgb_d1;
  logic             hit_d;

  // Stage 1: ROM request plus timing/background delay
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
      rom_sel  <= 1'b0;
      hit_d    <= 1'b0;
      tim_d1   <= '0;
      rgb_d1   <= '0;
    end else begin
      rom_addr <= addr_nxt;
      rom_sel  <= pick_water;
      hit_d    <= any_hit & ~(hblnk_in | vblnk_in);
      tim_d1   <= '{hcount: hcount_in, vcount: vcount_in,
                    blnk: {hblnk_in, vblnk_in}, sync: {hsync_in, vsync_in}};
      rgb_d1   <= rgb_in;
    end
  end

  // Stage 2: composite; a transparent winner pixel shows background
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tim_d2  <= '0;
      rgb_out <= '0;
    end else begin
      tim_d2  <= tim_d1;
      rgb_out <= (hit_d && (rom_rgb != KEY_RGB)) ? rom_rgb : rgb_d1;
    end
  end

  assign hcount_out = tim_d2.hcount;
  assign vcount_out = tim_d2.vcount;
  assign hblnk_out  = tim_d2.blnk[1];
  assign vblnk_out  = tim_d2.blnk[0];
  assign hsync_out  = tim_d2.sync[1];
  assign vsync_out  = tim_d2.sync[0];

endmodule
